iter_mul_unit: RTL and testbench



---
 rtl/iter_mul_unit_if.sv | 13 +
 rtl/iter_mul_unit.sv | 76 +++++++
 tb/tb_iter_mul_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/iter_mul_unit_if.sv
// iter_mul_unit_if: start/operand/result bundle between the control unit and the multiplier
interface iter_mul_unit_if #(parameter int WIDTH = 32);
    logic start;
    logic is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic busy;
    logic done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    modport master(output start, is_signed, a, b, input busy, done, result_hi, result_lo);
    modport slave(input start, is_signed, a, b, output busy, done, result_hi, result_lo);
endinterface

// File: rtl/iter_mul_unit.sv
// iter_mul_unit: iterative shift-add multiplier for MULT/MULTU, WIDTH+1 cycle latency
// MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero
module iter_mul_unit #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    iter_mul_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] mcand, mplier, acc, hi, lo;
    logic [CW-1:0] cnt;
    logic neg, accept, last;
    logic [WIDTH:0] sum;
    logic [2*WIDTH-1:0] nxt, prod;
`ifdef MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0] rem;
`endif
    assign accept = bus.start && state != BUSY;
    assign bus.busy = state == BUSY;
    assign bus.done = state == DONE;
    assign bus.result_hi = hi;
    assign bus.result_lo = lo;
    always_comb begin
        sum = {1'b0, acc} + {1'b0, mplier[0] ? mcand : '0};
        nxt = {sum, mplier[WIDTH-1:1]};
`ifdef MUL_EARLY_EXIT_EN
        last = cnt == CW'(WIDTH - 1) || rem[WIDTH-1:1] == '0;
        prod = nxt >> (CW'(WIDTH - 1) - cnt);
`else
        last = cnt == CW'(WIDTH - 1);
        prod = nxt;
`endif
        state_nx = state == BUSY ? (last ? DONE : BUSY) : (accept ? BUSY : IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            neg <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mcand <= bus.is_signed && bus.a[WIDTH-1] ? -bus.a : bus.a;
                mplier <= bus.is_signed && bus.b[WIDTH-1] ? -bus.b : bus.b;
                neg <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                acc <= '0;
                cnt <= '0;
            end else if (state == BUSY) begin
                acc <= nxt[2*WIDTH-1:WIDTH];
                mplier <= nxt[WIDTH-1:0];
                cnt <= cnt + 1'b1;
                if (last)
                    {hi, lo} <= neg ? -prod : prod;
            end
        end
    end
`ifdef MUL_EARLY_EXIT_EN
    // unconsumed multiplier bits, tracked apart from the product-mixed shift register
    always_ff @(posedge clk) begin
        if (rst)
            rem <= '0;
        else if (accept)
            rem <= bus.is_signed && bus.b[WIDTH-1] ? -bus.b : bus.b;
        else if (state == BUSY)
            rem <= rem >> 1;
    end
`endif
endmodule

// File: tb/tb_iter_mul_unit.sv
// tb_iter_mul_unit: directed vectors with hand-computed products and latencies
module tb_iter_mul_unit;
    localparam int W = 32;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    iter_mul_unit_if #(.WIDTH(W)) bus();
    iter_mul_unit #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.is_signed = 1'($urandom);
    endtask
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] prod, input int lat_ee);
        int k = 0;
        int nb = 0;
        int lat = EE ? lat_ee : W + 1;
        issue(a, b, s);
        do begin
            @(negedge clk);
            k++;
            nb += int'(bus.busy);
        end while (!bus.done && k < 100);
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_busy"}, 64'(nb), 64'(lat - 1));
        check({tag, "_prod"}, {bus.result_hi, bus.result_lo}, prod);
    endtask
    initial begin : main
        logic seen;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_res", {bus.result_hi, bus.result_lo}, 64'd0);
        bus.start = 1'b1;
        bus.a = 32'd6;
        bus.b = 32'd7;
        @(negedge clk);
        check("rst_over_start", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        run("t1", 32'd6, 32'd7, 1'b0, 64'd42, 4);
        @(negedge clk);
        check("t1_done_pulse", 64'(bus.done), 64'd0);
        @(negedge clk);
        check("t1_hold", {bus.result_hi, bus.result_lo}, 64'd42);
        run("t2", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 4);
        @(negedge clk);
        run("t3s", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33);
        @(negedge clk);
        run("t3u", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 33);
        @(negedge clk);
        run("t4", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33);
        run("t4b2b", 32'd2, 32'd3, 1'b0, 64'd6, 3);
        @(negedge clk);
        run("t7", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001, 2);
        @(negedge clk);
        seen = 1'b0;
        issue(32'd9, 32'd9, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            seen |= bus.done;
            if (k == 5) begin
                bus.start = 1'b1;
                bus.a = 32'd1;
                bus.b = 32'd1;
            end
            if (k == 6) bus.start = 1'b0;
            if (k == 9) check("t5_busy_mid", 64'(bus.busy), 64'(!EE));
            if (k == 10) rst = 1'b1;
            if (k == 11) begin
                check("t5_busy_rst", 64'(bus.busy), 64'd0);
                check("t5_res_rst", {bus.result_hi, bus.result_lo}, 64'd0);
            end
        end
        check("t5_no_done", 64'(seen), 64'(EE));
        rst = 1'b0;
        @(negedge clk);
        run("t6a", 32'd100, 32'd3, 1'b0, 64'd300, 3);
        @(negedge clk);
        run("t6b", 32'd5, 32'd0, 1'b0, 64'd0, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
